// File: rtl/mem_noc_arb_4to1_if.sv
// mem_noc_pkg / mem_noc_arb_4to1_if
// Purpose: request/response payload types and one valid/ready channel pair
//          (request toward the slave, response back to the master).
// Modports:
//   master : drives req_valid/req/resp_ready, receives req_ready/resp_valid/resp
//   slave  : receives req_valid/req/resp_ready, drives req_ready/resp_valid/resp

package mem_noc_pkg;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;
endpackage

interface mem_noc_arb_4to1_if;
  import mem_noc_pkg::*;

  logic      req_valid;
  logic      req_ready;
  mem_req_t  req;
  logic      resp_valid;
  logic      resp_ready;
  mem_resp_t resp;

  modport master (
    output req_valid, req, resp_ready,
    input  req_ready, resp_valid, resp
  );

  modport slave (
    input  req_valid, req, resp_ready,
    output req_ready, resp_valid, resp
  );
endinterface

// File: rtl/mem_noc_arb_4to1.sv
// mem_noc_arb_4to1
// Purpose: 4-to-1 memory request arbiter with a single outstanding transaction.
//          Requests are forwarded combinationally from the winning master to the
//          shared slave; the response is routed back to the master that owns the
//          outstanding transaction.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   mn0..mn3 : per-master channels (slave modport, the arbiter serves them)
//   sn       : shared slave channel (master modport, the arbiter drives it)
// Parameter:
//   ARB_RR   : 1 = round-robin from rr_ptr, 0 = fixed priority, master 0 highest

module mem_noc_arb_4to1
  import mem_noc_pkg::*;
#(
  parameter int unsigned ARB_RR = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_noc_arb_4to1_if.slave  mn0,
  mem_noc_arb_4to1_if.slave  mn1,
  mem_noc_arb_4to1_if.slave  mn2,
  mem_noc_arb_4to1_if.slave  mn3,
  mem_noc_arb_4to1_if.master sn
);

  typedef enum logic [0:0] {StArb, StResp} state_e;

  state_e     r_state;
  logic [1:0] r_rr_ptr;
  logic [1:0] r_owner;  // locked master while in StArb, transaction owner in StResp
  logic       r_lock;

  logic [3:0] w_req_valid;
  logic [3:0] w_resp_ready;
  mem_req_t   w_req [4];

  assign w_req_valid  = {mn3.req_valid, mn2.req_valid, mn1.req_valid, mn0.req_valid};
  assign w_resp_ready = {mn3.resp_ready, mn2.resp_ready, mn1.resp_ready, mn0.resp_ready};
  assign w_req[0]     = mn0.req;
  assign w_req[1]     = mn1.req;
  assign w_req[2]     = mn2.req;
  assign w_req[3]     = mn3.req;

  logic [1:0] w_base;
  logic [1:0] w_win;
  logic       w_have;

  // Scan from highest offset down so the lowest offset from the base wins.
  always_comb begin
    w_base = (ARB_RR != 0) ? r_rr_ptr : 2'd0;
    w_win  = w_base;
    w_have = 1'b0;
    if (r_lock) begin
      w_win  = r_owner;
      w_have = 1'b1;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (w_req_valid[w_base + 2'(i)]) begin
          w_win  = w_base + 2'(i);
          w_have = 1'b1;
        end
      end
    end
  end

  // Gating with rst keeps every handshake output low while reset is held.
  logic w_arb;
  logic w_resp_st;
  logic w_sn_req_valid;
  logic w_req_hs;
  logic w_resp_hs;
  logic w_grant_rdy;
  logic w_owner_resp_valid;

  assign w_arb              = !rst && (r_state == StArb);
  assign w_resp_st          = !rst && (r_state == StResp);
  assign w_sn_req_valid     = w_arb && w_req_valid[w_win];
  assign w_req_hs           = w_sn_req_valid && sn.req_ready;
  assign w_grant_rdy        = w_arb && w_have && sn.req_ready;
  assign w_owner_resp_valid = w_resp_st && sn.resp_valid;
  assign w_resp_hs          = w_owner_resp_valid && w_resp_ready[r_owner];

  // Slave request channel
  assign sn.req_valid  = w_sn_req_valid;
  assign sn.req        = w_req[w_win];
  assign sn.resp_ready = w_resp_st && w_resp_ready[r_owner];

  // Master request readies: only the current winner sees the slave ready
  assign mn0.req_ready = w_grant_rdy && (w_win == 2'd0);
  assign mn1.req_ready = w_grant_rdy && (w_win == 2'd1);
  assign mn2.req_ready = w_grant_rdy && (w_win == 2'd2);
  assign mn3.req_ready = w_grant_rdy && (w_win == 2'd3);

  // Response payload is broadcast; only valid is steered to the owner
  assign mn0.resp       = sn.resp;
  assign mn1.resp       = sn.resp;
  assign mn2.resp       = sn.resp;
  assign mn3.resp       = sn.resp;
  assign mn0.resp_valid = w_owner_resp_valid && (r_owner == 2'd0);
  assign mn1.resp_valid = w_owner_resp_valid && (r_owner == 2'd1);
  assign mn2.resp_valid = w_owner_resp_valid && (r_owner == 2'd2);
  assign mn3.resp_valid = w_owner_resp_valid && (r_owner == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StArb;
      r_rr_ptr <= 2'd0;
      r_owner  <= 2'd0;
      r_lock   <= 1'b0;
    end else begin
      unique case (r_state)
        StArb: begin
          if (w_req_hs) begin
            r_owner <= w_win;
            r_lock  <= 1'b0;
            r_state <= StResp;
            if (ARB_RR != 0) begin
              r_rr_ptr <= w_win + 2'd1;
            end
          end else if (w_sn_req_valid) begin
            // Stalled request: hold the grant so the forwarded payload stays stable.
            r_lock  <= 1'b1;
            r_owner <= w_win;
          end
        end
        StResp: begin
          if (w_resp_hs) begin
            r_state <= StArb;
          end
        end
        default: r_state <= StArb;
      endcase
    end
  end

endmodule

// File: doc/mem_noc_arb_4to1.md
MEM_NOC_ARB_4TO1 -- requirements
Module: mem_noc_arb_4to1

Interface
REQ-001 Parameter ARB_RR, default 1, SHALL select round-robin arbitration (1) or fixed priority with master 0 highest (0).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset, asynchronous and active-high.
REQ-004 Ports mn0..mn3_req_valid, input, 1 each, SHALL be the per-master request valids.
REQ-005 Ports mn0..mn3_req_ready, output, 1 each, SHALL be the per-master request readies.
REQ-006 Ports mn0..mn3_req, input, mem_req_t each, SHALL be the per-master request payloads.
REQ-007 Ports mn0..mn3_resp_valid, output, 1 each, SHALL be the per-master response valids.
REQ-008 Ports mn0..mn3_resp_ready, input, 1 each, SHALL be the per-master response readies.
REQ-009 Ports mn0..mn3_resp, output, mem_resp_t each, SHALL be the per-master response payloads.
REQ-010 Ports sn_req_valid/sn_req_ready/sn_req, output/input/output, 1/1/mem_req_t, SHALL form the shared slave request channel.
REQ-011 Ports sn_resp_valid/sn_resp_ready/sn_resp, input/output/input, 1/1/mem_resp_t, SHALL form the shared slave response channel.

Function
REQ-012 Block SHALL have two states: ARB (accepting a request) and RESP (one transaction outstanding); at most one transaction outstanding at any time.
REQ-013 In ARB with no lock, winner SHALL be the first valid master scanning from rr_ptr upward modulo 4 (ARB_RR=1) or from index 0 (ARB_RR=0).
REQ-014 In ARB, sn_req_valid SHALL equal the winner's req_valid and sn_req SHALL equal the winner's payload, combinationally (zero-cycle latency).
REQ-015 In ARB, winner's mn_req_ready SHALL equal sn_req_ready; all other mn_req_ready SHALL be 0; in RESP all mn_req_ready and sn_req_valid SHALL be 0.
REQ-016 If sn_req_valid=1 and sn_req_ready=0, grant SHALL lock to that master on the next cycle and remain locked until its request handshake, regardless of other valids (payload stability).
REQ-017 On request handshake (sn_req_valid && sn_req_ready), owner register SHALL capture winner index, lock SHALL clear, state SHALL go ARB->RESP, and (ARB_RR=1) rr_ptr SHALL become (winner+1) mod 4.
REQ-018 In RESP, owner's mn_resp_valid SHALL equal sn_resp_valid, owner's mn_resp SHALL equal sn_resp, sn_resp_ready SHALL equal owner's mn_resp_ready; non-owners SHALL see resp_valid=0.
REQ-019 All mn_resp payloads SHALL be driven with sn_resp (only valid is gated); in ARB all mn_resp_valid and sn_resp_ready SHALL be 0.
REQ-020 On response handshake in RESP, state SHALL return to ARB next cycle; next arbitration occurs in that ARB cycle (minimum 1-cycle gap between response and next request acceptance).
REQ-021 sn_resp_valid asserted while in ARB SHALL be ignored (not forwarded, not acknowledged).
REQ-022 Master deasserting req_valid while locked is a protocol violation; block SHALL keep lock and sn_req_valid SHALL follow the (deasserted) valid.
REQ-023 Arbitration counters/pointers SHALL be 2 bits and wrap 3->0.

Reset
REQ-024 While rst=1: state=ARB, rr_ptr=0, owner=0, lock=0; all mn_req_ready, mn_resp_valid, sn_req_valid, sn_resp_ready SHALL be 0 after reset with no valid inputs.
REQ-025 Reset asserted mid-transaction SHALL drop the outstanding transaction immediately (asynchronous); first post-reset arbitration SHALL start from master 0.

Verification
REQ-026 Single request: mn2 valid, addr 0x0200_0000, sn_req_ready=1 -> handshake same cycle, state RESP; sn_resp data 0xA5 returned only on mn2_resp, rr_ptr=3.
REQ-027 Round-robin fairness: all four valid continuously, slave 1-cycle response -> grant order 0,1,2,3,0 over five transactions.
REQ-028 Lock: mn1 and mn3 valid, rr_ptr=2, sn_req_ready=0 for 3 cycles, then mn1 drops out and returns -> mn3 stays granted with stable payload until handshake on cycle 4.
REQ-029 Response backpressure: owner mn0_resp_ready=0 for 5 cycles -> sn_resp_ready=0 for 5 cycles, no new request accepted, all mn_req_ready=0.
REQ-030 Fixed priority (ARB_RR=0): mn1 and mn3 valid repeatedly -> mn1 always wins; mn3 granted only when mn1 idle.
REQ-031 Reset during RESP: rst pulse 1 cycle -> all outputs 0, state ARB, next grant with all valid goes to mn0.
